// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and per-level selectors used by the Decompose datapath.
package dilithium_pkg;

   localparam int COEFF_BITS = 24;
   localparam int T_BITS     = 7;
   localparam int C_BITS     = 20;
   localparam int BARRETT_K  = 41;

   localparam logic [COEFF_BITS-1:0] Q = 24'd8380417;

   localparam logic [C_BITS-1:0] N1 = 20'd190464;
   localparam logic [C_BITS-1:0] N2 = 20'd523776;

   localparam logic [COEFF_BITS-1:0] Q_MINUS_N1 = 24'd8189953;
   localparam logic [COEFF_BITS-1:0] Q_MINUS_N2 = 24'd7856641;

   localparam logic [COEFF_BITS-1:0] M1 = 24'd11545611;
   localparam logic [COEFF_BITS-1:0] M2 = 24'd4198404;

   localparam logic [2:0] SEC_LVL_2 = 3'b010;

   // r1 value at which r - r0 reaches q-1 and the result wraps to r1 = 0
   localparam logic [T_BITS-1:0] R1_WRAP_1 = 7'd44;
   localparam logic [T_BITS-1:0] R1_WRAP_2 = 7'd16;

   typedef enum logic {GAMMA_Q32, GAMMA_Q88} gamma_sel_e;

   function automatic gamma_sel_e gamma_sel(input logic [2:0] sec_lvl);
      return (sec_lvl == SEC_LVL_2) ? GAMMA_Q88 : GAMMA_Q32;
   endfunction

   function automatic logic [COEFF_BITS-1:0] barrett_m(input gamma_sel_e sel);
      return (sel == GAMMA_Q88) ? M1 : M2;
   endfunction

   function automatic logic [C_BITS-1:0] mod_n(input gamma_sel_e sel);
      return (sel == GAMMA_Q88) ? N1 : N2;
   endfunction

   function automatic logic [C_BITS-1:0] half_n(input gamma_sel_e sel);
      return (sel == GAMMA_Q88) ? (N1 >> 1) : (N2 >> 1);
   endfunction

   function automatic logic [COEFF_BITS-1:0] q_minus_n(input gamma_sel_e sel);
      return (sel == GAMMA_Q88) ? Q_MINUS_N1 : Q_MINUS_N2;
   endfunction

   function automatic logic [T_BITS-1:0] r1_wrap(input gamma_sel_e sel);
      return (sel == GAMMA_Q88) ? R1_WRAP_1 : R1_WRAP_2;
   endfunction

endpackage

// File: rtl/decompose_lane.sv
// Single-coefficient Decompose datapath: Barrett quotient, remainder correction,
// centred reduction, then the q-1 wrap fix into registered outputs.
module decompose_lane
   import dilithium_pkg::*;
#(
   parameter int COEFF_W = 24
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  gamma_sel_e         sel_in,
   input  gamma_sel_e         sel_s1,
   input  gamma_sel_e         sel_s2,
   input  gamma_sel_e         sel_s3,
   input  logic [COEFF_W-1:0] r,
   output logic [COEFF_W-1:0] r0,
   output logic [COEFF_W-1:0] r1
);

   logic [47:0]            prod;
   logic [T_BITS-1:0]      t_est;
   logic [COEFF_BITS-1:0]  r_s1;
   logic [T_BITS-1:0]      t_s1;

   logic [COEFF_BITS:0]    tn;
   logic [COEFF_BITS:0]    c_raw;
   logic [C_BITS-1:0]      c_nxt;
   logic [T_BITS-1:0]      t_nxt;
   logic [C_BITS-1:0]      c_s2;
   logic [T_BITS-1:0]      t_s2;

   logic [COEFF_BITS-1:0]  r0_mid;
   logic [T_BITS-1:0]      r1_mid;
   logic [COEFF_BITS-1:0]  r0_s3;
   logic [T_BITS-1:0]      r1_s3;

   logic [COEFF_BITS-1:0]  r0_fin;
   logic [T_BITS-1:0]      r1_fin;

   // Barrett estimate never exceeds floor(r/N) and undershoots by at most one.
   always_comb begin
      prod  = 48'(r[COEFF_BITS-1:0]) * 48'(barrett_m(sel_in));
      t_est = T_BITS'(prod >> BARRETT_K);
   end

   always_comb begin
      tn    = (COEFF_BITS+1)'(t_s1) * (COEFF_BITS+1)'(mod_n(sel_s1));
      c_raw = {1'b0, r_s1} - tn;
      c_nxt = C_BITS'(c_raw);
      t_nxt = t_s1;
      if (c_raw >= (COEFF_BITS+1)'(mod_n(sel_s1))) begin
         c_nxt = C_BITS'(c_raw - (COEFF_BITS+1)'(mod_n(sel_s1)));
         t_nxt = t_s1 + 7'd1;
      end
   end

   // Negative r0 values are carried as r0 + q so every stored low part is in [0,q).
   always_comb begin
      r0_mid = COEFF_BITS'(c_s2);
      r1_mid = t_s2;
      if (c_s2 > half_n(sel_s2)) begin
         r0_mid = COEFF_BITS'(c_s2) + q_minus_n(sel_s2);
         r1_mid = t_s2 + 7'd1;
      end
   end

   always_comb begin
      r0_fin = r0_s3;
      r1_fin = r1_s3;
      if (r1_s3 == r1_wrap(sel_s3)) begin
         r1_fin = '0;
         r0_fin = (r0_s3 == '0) ? Q - 24'd1 : r0_s3 - 24'd1;
      end
   end

   // NOTE: internal stage data is never consumed without its valid bit, so only
   // the valid chain and the visible outputs need a reset.
   always_ff @(posedge clk) begin
      if (en) begin
         r_s1  <= r[COEFF_BITS-1:0];
         t_s1  <= t_est;
         c_s2  <= c_nxt;
         t_s2  <= t_nxt;
         r0_s3 <= r0_mid;
         r1_s3 <= r1_mid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r0 <= '0;
         r1 <= '0;
      end else if (en) begin
         r0 <= COEFF_W'(r0_fin);
         r1 <= COEFF_W'(r1_fin);
      end
   end

endmodule

// File: rtl/coeff_decomposer.sv
// Multi-lane Dilithium Decompose with a stallable valid/ready pipeline; every lane
// shares the stage enables, valid chain and per-stage security-level selection.
module coeff_decomposer
   import dilithium_pkg::*;
#(
   parameter int OUTPUT_W = 4,
   parameter int COEFF_W  = 24
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  sec_lvl,
   input  logic                        valid_i,
   output logic                        ready_i,
   input  logic [OUTPUT_W*COEFF_W-1:0] di,
   output logic [OUTPUT_W*COEFF_W-1:0] doa,
   output logic [OUTPUT_W*COEFF_W-1:0] dob,
   output logic                        valid_o,
   input  logic                        ready_o
);

   logic       en;
   logic       v_s1;
   logic       v_s2;
   logic       v_s3;
   gamma_sel_e sel_in;
   gamma_sel_e sel_s1;
   gamma_sel_e sel_s2;
   gamma_sel_e sel_s3;

   // The whole pipe moves as one, so the upstream sees exactly the downstream ready.
   assign en      = ready_o;
   assign ready_i = ready_o;
   assign sel_in  = gamma_sel(sec_lvl);

   always_ff @(posedge clk) begin
      if (rst) begin
         v_s1    <= 1'b0;
         v_s2    <= 1'b0;
         v_s3    <= 1'b0;
         valid_o <= 1'b0;
      end else if (en) begin
         v_s1    <= valid_i;
         v_s2    <= v_s1;
         v_s3    <= v_s2;
         valid_o <= v_s3;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         sel_s1 <= sel_in;
         sel_s2 <= sel_s1;
         sel_s3 <= sel_s2;
      end
   end

   for (genvar k = 0; k < OUTPUT_W; k++) begin : g_lane
      decompose_lane #(
         .COEFF_W (COEFF_W)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .sel_in (sel_in),
         .sel_s1 (sel_s1),
         .sel_s2 (sel_s2),
         .sel_s3 (sel_s3),
         .r      (di[k*COEFF_W +: COEFF_W]),
         .r0     (doa[k*COEFF_W +: COEFF_W]),
         .r1     (dob[k*COEFF_W +: COEFF_W])
      );
   end

endmodule

// File: tb/tb_coeff_decomposer.sv
// Self-checking bench for coeff_decomposer: directed vectors plus randomized traffic
// against an arithmetic Decompose model and a latency/stall-aware output scoreboard.
module tb_coeff_decomposer;

   localparam int     LANES = 4;
   localparam int     CW    = 24;
   localparam int     W     = LANES * CW;
   localparam int     LAT   = 3;
   localparam longint QM    = 8380417;
   localparam logic [2:0] LVL2 = 3'b010;
   localparam logic [2:0] LVL3 = 3'b011;

   typedef struct {
      logic         v;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } slot_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   sec_lvl;
   logic         valid_i;
   logic         ready_i;
   logic [W-1:0] di;
   logic [W-1:0] doa;
   logic [W-1:0] dob;
   logic         valid_o;
   logic         ready_o;

   int    errors = 0;
   int    checks = 0;
   slot_t pipe[$];
   slot_t exp_out;

   always #5 clk = ~clk;

   coeff_decomposer #(
      .OUTPUT_W (LANES),
      .COEFF_W  (CW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sec_lvl (sec_lvl),
      .valid_i (valid_i),
      .ready_i (ready_i),
      .di      (di),
      .doa     (doa),
      .dob     (dob),
      .valid_o (valid_o),
      .ready_o (ready_o)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Decompose straight from the definition: centred remainder mod 2*gamma2.
   function automatic void decompose(input longint r, input logic [2:0] lvl,
                                     output longint r0, output longint r1);
      longint g2;
      longint a;
      longint lo;
      g2 = (lvl == LVL2) ? (QM - 1) / 88 : (QM - 1) / 32;
      a  = 2 * g2;
      lo = r % a;
      if (lo > g2) lo = lo - a;
      if (r - lo == QM - 1) begin
         r1 = 0;
         lo = lo - 1;
      end else begin
         r1 = (r - lo) / a;
      end
      r0 = (lo < 0) ? lo + QM : lo;
   endfunction

   function automatic logic [2*W-1:0] model_beat(input logic [W-1:0] d, input logic [2:0] lvl);
      logic [W-1:0] a;
      logic [W-1:0] b;
      longint       r0;
      longint       r1;
      for (int k = 0; k < LANES; k++) begin
         decompose(longint'(d[k*CW +: CW]), lvl, r0, r1);
         a[k*CW +: CW] = CW'(r0);
         b[k*CW +: CW] = CW'(r1);
      end
      return {b, a};
   endfunction

   function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
      return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
   endfunction

   // Mostly uniform, with a bias toward multiples of N and N/2 boundaries.
   function automatic logic [CW-1:0] rand_r(input logic [2:0] lvl);
      longint n;
      longint v;
      n = (lvl == LVL2) ? 190464 : 523776;
      case ($urandom_range(0, 3))
         0: v = longint'($urandom_range(0, 44)) * n + longint'($urandom_range(0, 2)) - 1;
         1: v = longint'($urandom_range(0, 44)) * n + n / 2 + longint'($urandom_range(0, 2)) - 1;
         default: v = longint'($urandom_range(0, 32'(QM - 1)));
      endcase
      if (v < 0) v = 0;
      if (v > QM - 1) v = v % QM;
      return CW'(v);
   endfunction

   function automatic logic [W-1:0] rand_beat(input logic [2:0] lvl);
      logic [W-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*CW +: CW] = rand_r(lvl);
      return d;
   endfunction

   // One clock: drive at negedge, check ready_i, advance the scoreboard at the edge,
   // then compare outputs at the following negedge.
   task automatic cycle(input logic rst_v, input logic v, input logic [W-1:0] d,
                        input logic [2:0] lvl, input logic rdy,
                        input logic [W-1:0] ea, input logic [W-1:0] eb);
      slot_t s;
      rst     = rst_v;
      valid_i = v;
      di      = d;
      sec_lvl = lvl;
      ready_o = rdy;
      #1;
      check("ready_i", W'(ready_i), W'(rdy));
      @(posedge clk);
      if (rst_v) begin
         pipe.delete();
         s.v = 1'b0;
         s.a = '0;
         s.b = '0;
         for (int i = 0; i < LAT; i++) pipe.push_back(s);
         exp_out = s;
      end else if (rdy) begin
         s.v = v;
         s.a = v ? ea : '0;
         s.b = v ? eb : '0;
         pipe.push_back(s);
         exp_out = pipe.pop_front();
      end
      @(negedge clk);
      check("valid_o", W'(valid_o), W'(exp_out.v));
      if (exp_out.v || rst_v) begin
         check("doa", doa, exp_out.a);
         check("dob", dob, exp_out.b);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] lvl, input logic rdy);
      logic [2*W-1:0] m;
      m = model_beat(d, lvl);
      cycle(1'b0, v, d, lvl, rdy, m[W-1:0], m[2*W-1:W]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, LVL2, 1'b1);
   endtask

   initial begin
      logic [W-1:0] beats[8];
      logic [2:0]   lv[8];
      logic [2:0]   rl;
      int           idx;
      int           cyc;
      logic         rdy;

      rst     = 1'b1;
      valid_i = 1'b0;
      di      = '0;
      sec_lvl = LVL2;
      ready_o = 1'b1;
      @(negedge clk);

      cycle(1'b1, 1'b0, '0, LVL2, 1'b1, '0, '0);
      cycle(1'b1, 1'b0, '0, LVL2, 1'b1, '0, '0);

      // All-zero beat at level 2, then the two spec vector sets.
      cycle(1'b0, 1'b1, '0, LVL2, 1'b1, '0, '0);
      idle(4);
      cycle(1'b0, 1'b1, pack4(95232, 95233, 190464, 8380416), LVL2, 1'b1,
            pack4(95232, 8285186, 0, 8380416), pack4(0, 1, 1, 0));
      cycle(1'b0, 1'b1, pack4(261888, 261889, 523776, 8380416), LVL3, 1'b1,
            pack4(261888, 8118530, 0, 8380416), pack4(0, 1, 1, 0));
      idle(4);

      // Eight-beat stream with ready_o low for three cycles in the middle.
      for (int k = 0; k < 8; k++) begin
         lv[k]    = (k % 2 == 0) ? LVL2 : LVL3;
         beats[k] = rand_beat(lv[k]);
      end
      idx = 0;
      cyc = 0;
      while (idx < 8) begin
         rdy = !(cyc >= 4 && cyc <= 6);
         drive(1'b1, beats[idx], lv[idx], rdy);
         if (rdy) idx++;
         cyc++;
      end
      idle(4);

      // Reset with two beats in flight, then confirm post-reset latency.
      drive(1'b1, rand_beat(LVL2), LVL2, 1'b1);
      drive(1'b1, rand_beat(LVL3), LVL3, 1'b1);
      cycle(1'b1, 1'b0, '0, LVL2, 1'b1, '0, '0);
      idle(4);
      drive(1'b1, rand_beat(LVL3), LVL3, 1'b1);
      idle(4);

      // Randomized traffic: random levels, valid gaps and downstream stalls.
      for (int i = 0; i < 400; i++) begin
         rl = 3'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, rand_beat(rl), rl, $urandom_range(0, 3) != 0);
      end
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coeff_decomposer.md
COEFF_DECOMPOSER -- requirements
Module: coeff_decomposer

Interface
REQ-001 Parameters: OUTPUT_W, default 4, coefficient lanes per beat; COEFF_W, default 24, bits per coefficient.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 sec_lvl  input  3  security level: 3'b010 selects Dilithium2 (gamma2=(q-1)/88); any other value selects gamma2=(q-1)/32.
REQ-006 valid_i  input  1  upstream data valid.
REQ-007 ready_i  output  1  block ready for input.
REQ-008 di  input  OUTPUT_W*COEFF_W (96)  input coefficients r; lane k = bits [24k+23:24k], lane 0 in the LSBs.
REQ-009 doa  output  96  low parts r0, each held mod q in [0,q), same lane packing.
REQ-010 dob  output  96  high parts r1, zero-extended to 24 bits, same lane packing.
REQ-011 valid_o  output  1  output data valid.
REQ-012 ready_o  input  1  downstream ready.

Function
REQ-013 Constants: q=8380417; N=2*gamma2: N1=190464 (level 2), N2=523776 (other levels); q-N: 8189953 / 7856641; Barrett K=41, M1=11545611, M2=4198404.
REQ-014 Each lane computes Dilithium Decompose(r) independently using the same sec_lvl for all lanes.
REQ-015 Step 1: t=floor(r*M/2^41); c=r-t*N; if c>=N then c=c-N and t=t+1; result t=floor(r/N) and c=r mod N for every r in [0,q).
REQ-016 Step 2: if c>N/2 then r0=c-N (stored as c+(q-N)) and r1=t+1; else r0=c, r1=t.
REQ-017 Step 3: if r-r0 equals q-1 (r1=44 for level 2, r1=16 otherwise) then r1=0 and r0=r0-1 mod q.
REQ-018 Inputs SHALL lie in [0,q); outputs for inputs >=q are unconstrained but must not disturb the handshake or other beats.
REQ-019 Pipeline latency is exactly 3 clock cycles from an accepted beat to valid_o, with ready_o held high.
REQ-020 ready_i SHALL equal ready_o combinationally.
REQ-021 A beat is accepted on a rising edge with valid_i=1 and ready_i=1; sec_lvl is sampled with that beat.
REQ-022 All pipeline stages advance only while ready_o=1.
REQ-023 While ready_o=0, all stage registers, doa, dob and valid_o hold their values.
REQ-024 Throughput is one beat per cycle with ready_o=1.
REQ-025 Beats with valid_i=0 propagate as bubbles, so valid_o=0 three cycles later.
REQ-026 doa and dob are registered outputs; no combinational path exists from di to doa or dob.

Reset
REQ-027 With rst=1 at a clock edge, all stage valid bits, valid_o, doa and dob become 0.
REQ-028 Reset mid-operation discards all in-flight beats; the first accepted beat after reset appears 3 cycles after acceptance.

Structure
REQ-029 q, N1, N2, q-N values, K, M1, M2 and the sec_lvl encodings live in shared package dilithium_pkg.
REQ-030 One sub-module, decompose_lane, holds a single-coefficient 3-stage datapath; the top instantiates OUTPUT_W copies, shares the stage-valid/enable logic across lanes, and implements the handshake.

Verification
REQ-031 Level 2, all lanes r=0 -> doa=0, dob=0 per lane; valid_o=1 exactly 3 cycles after acceptance.
REQ-032 Level 2, lanes {95232,95233,190464,8380416} -> r0 {95232,8285186,0,8380416}, r1 {0,1,1,0}.
REQ-033 Level 3 (3'b011), lanes {261888,261889,523776,8380416} -> r0 {261888,8118530,0,8380416}, r1 {0,1,1,0}.
REQ-034 Stream 8 beats and drop ready_o low for 3 cycles mid-stream -> outputs frozen while low, no beat lost or duplicated, order preserved, ready_i mirrors ready_o.
REQ-035 Assert rst with 2 beats in flight -> valid_o, doa, dob = 0 next cycle; the in-flight beats never appear.
REQ-036 Random r in [0,q), both levels, compared against a software Decompose model -> exact match on all lanes.
